// File: rtl/types_pkg.sv
// Shared types for the dispatch slice: functional-unit codes, the renamed
// instruction payload and the ROB credit pool size.
package types_pkg;

  // ROB credit pool size; matches the 4-bit rob_tag.
  localparam int ROB_ENTRIES = 16;

  // Functional-unit selector; code 3 is reserved and dispatches as ALU.
  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MEM = 2'd1,
    FU_BR  = 2'd2
  } fu_t;

  // Renamed instruction payload carried from rename to the stations.
  typedef struct packed {
    fu_t        fu;
    logic [7:0] opcode;
    logic [5:0] dst_preg;
    logic [3:0] rob_tag;
  } rename_data;

endpackage

// File: rtl/dispatch_fifo.sv
// In-order DEPTH-entry buffer between rename and the reservation stations.
// Head is read combinationally so a pushed entry is visible the next cycle.
module dispatch_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  rename_data                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output rename_data                 head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rename_data       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [DEPTH-1:0] wr_en;

  // Pointer increment wrapping modulo DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // One write strobe per entry; a flush suppresses the write.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && !flush && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Next-state for pointers and occupancy; flush empties the buffer.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage, cleared on reset so the head reads as zero when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch stage: buffers renamed instructions, routes the head to the
// ALU/MEM/BR station, and gates dispatch on available ROB credits.
// A mispredict flushes the buffer and reloads the credit count.
module dispatch_ctrl
  import types_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int ROB_ENTRIES = types_pkg::ROB_ENTRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  rename_data data_in,
  output logic       ready_in,
  output logic       alu_valid,
  output logic       mem_valid,
  output logic       br_valid,
  input  logic       alu_ready,
  input  logic       mem_ready,
  input  logic       br_ready,
  output rename_data rs_data,
  output logic       rob_alloc,
  input  logic       commit_en,
  input  logic       mispredict,
  input  logic [4:0] credit_restore,
  output logic [4:0] credits
);

  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [4:0] CRED_MAX = 5'(ROB_ENTRIES);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [4:0]       credits_reg, credits_next;
  logic [CNT_W-1:0] fifo_count;
  rename_data       fifo_head;
  logic             push, pop, fire;
  logic             run_ok, issue_ok;
  logic             route_alu, route_mem, route_br;

  dispatch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .flush     (mispredict),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Open for business only when out of reset, in RUN and not being flushed.
  assign run_ok   = reset && (state_reg == ST_RUN) && !mispredict;
  assign ready_in = run_ok && (fifo_count < CNT_W'(DEPTH));
  assign issue_ok = run_ok && (fifo_count != '0) && (credits_reg != '0);

  // Station select from the head's unit code; reserved code 3 goes to ALU.
  always_comb begin
    route_alu = 1'b0;
    route_mem = 1'b0;
    route_br  = 1'b0;
    case (fifo_head.fu)
      FU_MEM:  route_mem = 1'b1;
      FU_BR:   route_br  = 1'b1;
      default: route_alu = 1'b1;
    endcase
  end

  assign alu_valid = issue_ok && route_alu;
  assign mem_valid = issue_ok && route_mem;
  assign br_valid  = issue_ok && route_br;
  assign fire      = (alu_valid && alu_ready) || (mem_valid && mem_ready) ||
                     (br_valid && br_ready);
  assign push      = valid_in && ready_in;
  assign pop       = fire;
  assign rob_alloc = fire;
  assign rs_data   = reset ? fifo_head : '0;
  assign credits   = credits_reg;

  // Credit bookkeeping: flush reloads (clamped, commit dropped); otherwise
  // one credit per dispatch out, one per commit back, saturating at full.
  always_comb begin
    credits_next = credits_reg;
    if (mispredict) begin
      credits_next = (credit_restore > CRED_MAX) ? CRED_MAX : credit_restore;
    end else begin
      if (fire) credits_next = credits_next - 5'd1;
      if (commit_en && (credits_reg != CRED_MAX)) credits_next = credits_next + 5'd1;
    end
  end

  // FLUSH lasts one cycle unless another mispredict arrives.
  always_comb begin
    state_next = mispredict ? ST_FLUSH : ST_RUN;
  end

  // State and credit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      credits_reg <= CRED_MAX;
    end else begin
      state_reg   <= state_next;
      credits_reg <= credits_next;
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: routing, backpressure, credit limits,
// flush behaviour and mid-operation reset.
module tb_dispatch_ctrl;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  rename_data data_in;
  logic       ready_in;
  logic       alu_valid, mem_valid, br_valid;
  logic       alu_ready, mem_ready, br_ready;
  rename_data rs_data;
  logic       rob_alloc;
  logic       commit_en;
  logic       mispredict;
  logic [4:0] credit_restore;
  logic [4:0] credits;

  int n_checks = 0;
  int n_pass   = 0;
  int alloc_cnt = 0;
  int base;
  int guard;
  rename_data d_alu, d_mem, d_br, d_rsv, m1, m2, m3, x1, x2;

  always #5 clk = ~clk;

  dispatch_ctrl #(.DEPTH(2), .ROB_ENTRIES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .ready_in       (ready_in),
    .alu_valid      (alu_valid),
    .mem_valid      (mem_valid),
    .br_valid       (br_valid),
    .alu_ready      (alu_ready),
    .mem_ready      (mem_ready),
    .br_ready       (br_ready),
    .rs_data        (rs_data),
    .rob_alloc      (rob_alloc),
    .commit_en      (commit_en),
    .mispredict     (mispredict),
    .credit_restore (credit_restore),
    .credits        (credits)
  );

  // Count ROB allocation pulses, sampled mid-cycle.
  always @(negedge clk) if (rob_alloc) alloc_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-22s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic rename_data mk(input fu_t fu, input int tag);
    rename_data d;
    d.fu       = fu;
    d.opcode   = 8'(8'h40 + tag);
    d.dst_preg = 6'(tag + 1);
    d.rob_tag  = 4'(tag);
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; data_in = '0;
    alu_ready = 1'b1; mem_ready = 1'b1; br_ready = 1'b1;
    commit_en = 1'b0; mispredict = 1'b0; credit_restore = 5'd0;
    d_alu = mk(FU_ALU, 1); d_mem = mk(FU_MEM, 2); d_br = mk(FU_BR, 3);
    d_rsv = mk(FU_ALU, 4); d_rsv.fu = fu_t'(2'd3);
    m1 = mk(FU_MEM, 5); m2 = mk(FU_MEM, 6); m3 = mk(FU_MEM, 7);
    x1 = mk(FU_ALU, 8); x2 = mk(FU_ALU, 9);

    // Reset state
    tick; tick;
    neg;
    check("rst_ready_in", 32'(ready_in), 0);
    check("rst_valids", {29'd0, alu_valid, mem_valid, br_valid}, 0);
    check("rst_rob_alloc", 32'(rob_alloc), 0);
    check("rst_rs_data", 32'(rs_data), 0);
    check("rst_credits", 32'(credits), 16);
    tick;
    reset = 1'b1;

    // ALU, MEM, BR back to back with all stations ready
    valid_in = 1'b1; data_in = d_alu;
    neg; check("t1_ready_after_rst", 32'(ready_in), 1);
    check("t1_c0_no_valid", 32'(alu_valid), 0);
    tick; data_in = d_mem;
    neg; check("t1_c1_valids", {29'd0, alu_valid, mem_valid, br_valid}, 3'b100);
    check("t1_c1_rs_data", 32'(rs_data), 32'(d_alu));
    check("t1_c1_rob_alloc", 32'(rob_alloc), 1);
    tick; data_in = d_br;
    neg; check("t1_c2_valids", {29'd0, alu_valid, mem_valid, br_valid}, 3'b010);
    check("t1_c2_rs_data", 32'(rs_data), 32'(d_mem));
    tick; valid_in = 1'b0;
    neg; check("t1_c3_valids", {29'd0, alu_valid, mem_valid, br_valid}, 3'b001);
    check("t1_c3_rs_data", 32'(rs_data), 32'(d_br));
    tick;
    neg; check("t1_c4_idle", {29'd0, alu_valid, mem_valid, br_valid}, 0);
    check("t1_credits", 32'(credits), 13);
    check("t1_alloc_pulses", 32'(alloc_cnt), 3);

    // Reserved unit code routes to ALU
    tick; valid_in = 1'b1; data_in = d_rsv;
    tick; valid_in = 1'b0;
    neg; check("rsv_route_alu", {29'd0, alu_valid, mem_valid, br_valid}, 3'b100);
    tick;
    neg; check("rsv_credits", 32'(credits), 12);

    // MEM backpressure: two accepts fill the buffer, head held stable
    tick; mem_ready = 1'b0; valid_in = 1'b1; data_in = m1;
    tick; data_in = m2;
    neg; check("t2_ready_one_entry", 32'(ready_in), 1);
    check("t2_rs_m1_a", 32'(rs_data), 32'(m1));
    check("t2_no_alloc", 32'(rob_alloc), 0);
    tick; data_in = m3;
    neg; check("t2_full_ready_in", 32'(ready_in), 0);
    check("t2_rs_m1_b", 32'(rs_data), 32'(m1));
    check("t2_mem_valid_held", 32'(mem_valid), 1);
    tick; valid_in = 1'b0; mem_ready = 1'b1;
    neg; check("t2_drain_m1", 32'(rs_data), 32'(m1));
    check("t2_drain_alloc1", 32'(rob_alloc), 1);
    tick;
    neg; check("t2_drain_m2", 32'(rs_data), 32'(m2));
    check("t2_drain_alloc2", 32'(rob_alloc), 1);
    tick;
    neg; check("t2_empty", 32'(mem_valid), 0);
    check("t2_credits", 32'(credits), 10);

    // Credit exhaustion: 17 pushes, only 16 dispatch until a commit
    tick; reset = 1'b0;
    tick; reset = 1'b1;
    base = alloc_cnt;
    for (int k = 0; k < 17; k++) begin
      valid_in = 1'b1; data_in = mk(FU_ALU, k);
      neg;
      guard = 0;
      while (!ready_in && guard < 20) begin
        tick; neg; guard++;
      end
      if (guard >= 20) check("t3_push_timeout", 32'(guard), 0);
      tick;
    end
    valid_in = 1'b0;
    tick;
    neg; check("t3_credits_zero", 32'(credits), 0);
    check("t3_valid_blocked", 32'(alu_valid), 0);
    check("t3_head_17th", 32'(rs_data), 32'(mk(FU_ALU, 16)));
    check("t3_alloc_16", 32'(alloc_cnt - base), 16);
    tick; commit_en = 1'b1;
    neg; check("t3_commit_cycle_blocked", 32'(alu_valid), 0);
    tick; commit_en = 1'b0;
    neg; check("t3_17th_valid", 32'(alu_valid), 1);
    check("t3_17th_alloc", 32'(rob_alloc), 1);
    tick;
    neg; check("t3_alloc_17", 32'(alloc_cnt - base), 17);
    check("t3_credits_after", 32'(credits), 0);

    // Fire and commit together at 5; saturation at 16 (via clamped restore)
    tick; commit_en = 1'b1;
    repeat (5) tick;
    commit_en = 1'b0;
    neg; check("t5_credits_5", 32'(credits), 5);
    tick; valid_in = 1'b1; data_in = x1;
    tick; valid_in = 1'b0; commit_en = 1'b1;
    neg; check("t5_fire", 32'(rob_alloc), 1);
    tick; commit_en = 1'b0;
    neg; check("t5_fire_commit_same", 32'(credits), 5);
    tick; mispredict = 1'b1; credit_restore = 5'd20;
    tick; mispredict = 1'b0;
    neg; check("t5_restore_clamped", 32'(credits), 16);
    tick; commit_en = 1'b1;
    tick; commit_en = 1'b0;
    neg; check("t5_commit_saturate", 32'(credits), 16);

    // Full buffer then mispredict with restore 9 (commit ignored)
    tick; alu_ready = 1'b0; valid_in = 1'b1; data_in = x1;
    tick; data_in = x2;
    tick; valid_in = 1'b0;
    neg; check("t4_full_ready_in", 32'(ready_in), 0);
    check("t4_head_valid", 32'(alu_valid), 1);
    tick; mispredict = 1'b1; credit_restore = 5'd9; commit_en = 1'b1;
    neg; check("t4_mp_ready_in", 32'(ready_in), 0);
    check("t4_mp_valid", 32'(alu_valid), 0);
    tick; mispredict = 1'b0; commit_en = 1'b0; alu_ready = 1'b1;
    neg; check("t4_credits_9", 32'(credits), 9);
    check("t4_flush_ready_in", 32'(ready_in), 0);
    tick;
    neg; check("t4_run_ready_in", 32'(ready_in), 1);
    check("t4_emptied", 32'(alu_valid), 0);
    // Second mispredict while in FLUSH extends it and reloads credits
    tick; mispredict = 1'b1; credit_restore = 5'd7;
    tick; credit_restore = 5'd3;
    tick; mispredict = 1'b0;
    neg; check("t4_flush_ext_ready", 32'(ready_in), 0);
    check("t4_flush_ext_credits", 32'(credits), 3);
    tick;
    neg; check("t4_flush_ext_run", 32'(ready_in), 1);

    // Reset mid-operation with a pending dispatch
    tick; alu_ready = 1'b0; valid_in = 1'b1; data_in = x1;
    tick; valid_in = 1'b0;
    neg; check("t6_pending_valid", 32'(alu_valid), 1);
    base = alloc_cnt;
    #2 reset = 1'b0; alu_ready = 1'b1;
    #1;
    check("t6_rst_valid", {29'd0, alu_valid, mem_valid, br_valid}, 0);
    check("t6_rst_ready_in", 32'(ready_in), 0);
    check("t6_rst_rs_data", 32'(rs_data), 0);
    tick; tick; reset = 1'b1;
    neg; check("t6_credits_16", 32'(credits), 16);
    check("t6_count_0", 32'(alu_valid), 0);
    check("t6_ready_in", 32'(ready_in), 1);
    check("t6_no_fire", 32'(alloc_cnt - base), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
